// File: rtl/riscv_approx_issue_pkg.sv
// ============================================================================
//  Module  : riscv_approx_issue_pkg
//  Brief   : Shared types and constants for the approximate-ALU issue stage:
//            operator encoding widths, mask widths, CSR addresses, issue FSM
//            state enum and the bundled operation struct.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_approx_issue_pkg;

  // Widths shared with the approximate ALU
  localparam int APP_OP_WIDTH = 7;
  localparam int N_BIT_APPR   = 8;
  localparam int N_BIT_PREC   = 8;

  // Approximate ALU operator encodings used by the issue path
  localparam logic [APP_OP_WIDTH-1:0] APP_ADD    = 7'h00;
  localparam logic [APP_OP_WIDTH-1:0] APP_MULMAC = 7'h01;
  localparam logic [APP_OP_WIDTH-1:0] APP_DOT8   = 7'h02;
  localparam logic [APP_OP_WIDTH-1:0] APP_SLL    = 7'h03;

  // CSR map of the issue stage
  localparam logic [11:0] APPX_CSR_APPR = 12'h7C0;
  localparam logic [11:0] APPX_CSR_PREC = 12'h7C1;
  localparam logic [11:0] APPX_CSR_STAT = 12'h7C2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } approx_issue_state_e;

  typedef struct packed {
    logic [APP_OP_WIDTH-1:0] op;
    logic [31:0]             operand_a;
    logic [31:0]             operand_b;
    logic [31:0]             operand_c;
    logic [1:0]              short_signed;
    logic [4:0]              imm;
    logic [1:0]              dot_signed;
  } approx_op_t;

  // Status word layout: {29'b0, draining, pending, out_valid}
  function automatic logic [31:0] appx_stat_word(input logic drain,
                                                 input logic pending,
                                                 input logic out_valid);
    return {29'b0, drain, pending, out_valid};
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_approx_cfg_regs.sv
// ============================================================================
//  Module  : riscv_approx_cfg_regs
//  Brief   : Approximation/precision mask configuration. CSR writes land in
//            shadow registers and raise a pending flag; the issue FSM decides
//            when the shadows are copied into the active masks (apply_i).
//            Optional perf counters enabled by RISCV_APPROX_PERF_CNT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_approx_cfg_regs
  import riscv_approx_issue_pkg::*;
#(
  parameter logic [11:0] CSR_ADDR_APPR = APPX_CSR_APPR,
  parameter logic [11:0] CSR_ADDR_PREC = APPX_CSR_PREC,
  parameter logic [11:0] CSR_ADDR_STAT = APPX_CSR_STAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  input  logic                  apply_i,
  input  logic                  retire_i,
  input  logic                  out_valid_i,
  input  logic                  drain_i,
  output logic                  cfg_wr_o,
  output logic                  pending_o,
  output logic [N_BIT_APPR-1:0] approx_mask_o,
  output logic [N_BIT_PREC-1:0] precision_mask_o
);

  logic [N_BIT_APPR-1:0] shadow_appr_q, shadow_appr_d;
  logic [N_BIT_PREC-1:0] shadow_prec_q, shadow_prec_d;
  logic [N_BIT_APPR-1:0] active_appr_q, active_appr_d;
  logic [N_BIT_PREC-1:0] active_prec_q, active_prec_d;
  logic                  pending_q, pending_d;
  logic                  wr_appr, wr_prec;

  // Upper write-data bits are don't-care for mask widths below 32
  logic unused_ok;
  assign unused_ok = ^{csr_wdata_i, retire_i};

  // Shadow capture and apply; a write colliding with an apply keeps pending set
  always_comb begin
    wr_appr       = csr_we_i && (csr_addr_i == CSR_ADDR_APPR);
    wr_prec       = csr_we_i && (csr_addr_i == CSR_ADDR_PREC);
    shadow_appr_d = wr_appr ? csr_wdata_i[N_BIT_APPR-1:0] : shadow_appr_q;
    shadow_prec_d = wr_prec ? csr_wdata_i[N_BIT_PREC-1:0] : shadow_prec_q;
    active_appr_d = apply_i ? shadow_appr_q : active_appr_q;
    active_prec_d = apply_i ? shadow_prec_q : active_prec_q;
    if (wr_appr || wr_prec) begin
      pending_d = 1'b1;
    end else if (apply_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Mask state; reset is exact arithmetic at full precision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_appr_q <= '0;
      shadow_prec_q <= '1;
      active_appr_q <= '0;
      active_prec_q <= '1;
      pending_q     <= 1'b0;
    end else begin
      shadow_appr_q <= shadow_appr_d;
      shadow_prec_q <= shadow_prec_d;
      active_appr_q <= active_appr_d;
      active_prec_q <= active_prec_d;
      pending_q     <= pending_d;
    end
  end

`ifdef RISCV_APPROX_PERF_CNT_EN
  localparam logic [11:0] CSR_ADDR_CNT_OPS  = CSR_ADDR_STAT + 12'd1;
  localparam logic [11:0] CSR_ADDR_CNT_APPR = CSR_ADDR_STAT + 12'd2;

  logic [31:0] cnt_ops_q, cnt_ops_d;
  logic [31:0] cnt_appr_q, cnt_appr_d;
  logic        cnt_clr;

  // Retire counters; a write to either counter address clears both
  always_comb begin
    cnt_clr    = csr_we_i && ((csr_addr_i == CSR_ADDR_CNT_OPS) ||
                              (csr_addr_i == CSR_ADDR_CNT_APPR));
    cnt_ops_d  = cnt_ops_q;
    cnt_appr_d = cnt_appr_q;
    if (cnt_clr) begin
      cnt_ops_d  = '0;
      cnt_appr_d = '0;
    end else if (retire_i) begin
      cnt_ops_d = cnt_ops_q + 32'd1;
      if (active_appr_q != '0) begin
        cnt_appr_d = cnt_appr_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ops_q  <= '0;
      cnt_appr_q <= '0;
    end else begin
      cnt_ops_q  <= cnt_ops_d;
      cnt_appr_q <= cnt_appr_d;
    end
  end
`endif

  // CSR readback, combinational on the address
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_ADDR_APPR: csr_rdata_o[N_BIT_APPR-1:0] = shadow_appr_q;
      CSR_ADDR_PREC: csr_rdata_o[N_BIT_PREC-1:0] = shadow_prec_q;
      CSR_ADDR_STAT: csr_rdata_o = appx_stat_word(drain_i, pending_q, out_valid_i);
`ifdef RISCV_APPROX_PERF_CNT_EN
      CSR_ADDR_CNT_OPS:  csr_rdata_o = cnt_ops_q;
      CSR_ADDR_CNT_APPR: csr_rdata_o = cnt_appr_q;
`endif
      default:       csr_rdata_o = '0;
    endcase
  end

  assign cfg_wr_o         = wr_appr || wr_prec;
  assign pending_o        = pending_q;
  assign approx_mask_o    = active_appr_q;
  assign precision_mask_o = active_prec_q;

endmodule

`default_nettype wire

// File: rtl/riscv_approx_issue.sv
// ============================================================================
//  Module  : riscv_approx_issue
//  Brief   : Single-entry issue register in front of the approximate ALU with
//            valid/ready handshakes. Mask updates are deferred to operation
//            boundaries so an in-flight operation never sees a mask change.
//            Optional perf counters: define RISCV_APPROX_PERF_CNT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_approx_issue
  import riscv_approx_issue_pkg::*;
#(
  parameter logic [11:0] CSR_ADDR_APPR = APPX_CSR_APPR,
  parameter logic [11:0] CSR_ADDR_PREC = APPX_CSR_PREC,
  parameter logic [11:0] CSR_ADDR_STAT = APPX_CSR_STAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    csr_we_i,
  input  logic [11:0]             csr_addr_i,
  input  logic [31:0]             csr_wdata_i,
  output logic [31:0]             csr_rdata_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [APP_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  input  logic [31:0]             operand_c_i,
  input  logic [1:0]              short_signed_i,
  input  logic [4:0]              imm_i,
  input  logic [1:0]              dot_signed_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [APP_OP_WIDTH-1:0] alu_operator_o,
  output logic [31:0]             alu_operand_a_o,
  output logic [31:0]             alu_operand_b_o,
  output logic [31:0]             alu_operand_c_o,
  output logic [1:0]              alu_short_signed_o,
  output logic [4:0]              alu_imm_o,
  output logic [1:0]              alu_dot_signed_o,
  output logic [N_BIT_APPR-1:0]   approx_mask_o,
  output logic [N_BIT_PREC-1:0]   precision_mask_o,
  output logic                    busy_o
);

  approx_issue_state_e state_q, state_d;
  approx_op_t          op_q, op_d, in_op;
  logic                pending;
  logic                cfg_wr;
  logic                pend_set;
  logic                accept;
  logic                retire;
  logic                apply;

  assign in_op = '{op:           operator_i,
                   operand_a:    operand_a_i,
                   operand_b:    operand_b_i,
                   operand_c:    operand_c_i,
                   short_signed: short_signed_i,
                   imm:          imm_i,
                   dot_signed:   dot_signed_i};

  // The state register alone tells whether an operation is held
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = !pending && (!out_valid_o || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign retire      = out_valid_o && out_ready_i;
  // Pending will be set next cycle (only used where no apply happens)
  assign pend_set    = pending || cfg_wr;
  assign busy_o      = out_valid_o || pending;

  // Issue FSM: a held op with pending config is DRAIN; apply at op boundaries
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = pend_set ? ST_DRAIN : ST_FULL;
        end else if (pending) begin
          apply = 1'b1;
        end
      end
      ST_FULL: begin
        if (retire) begin
          if (accept) begin
            state_d = pend_set ? ST_DRAIN : ST_FULL;
          end else begin
            state_d = ST_EMPTY;
            apply   = pending;
          end
        end else if (pend_set) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (retire) begin
          apply   = 1'b1;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Operation register loads only on accept, so fields hold under backpressure
  always_comb begin
    op_d = accept ? in_op : op_q;
  end

  // State and operation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  riscv_approx_cfg_regs #(
    .CSR_ADDR_APPR (CSR_ADDR_APPR),
    .CSR_ADDR_PREC (CSR_ADDR_PREC),
    .CSR_ADDR_STAT (CSR_ADDR_STAT)
  ) u_cfg_regs (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (csr_rdata_o),
    .apply_i          (apply),
    .retire_i         (retire),
    .out_valid_i      (out_valid_o),
    .drain_i          (state_q == ST_DRAIN),
    .cfg_wr_o         (cfg_wr),
    .pending_o        (pending),
    .approx_mask_o    (approx_mask_o),
    .precision_mask_o (precision_mask_o)
  );

  assign alu_operator_o     = op_q.op;
  assign alu_operand_a_o    = op_q.operand_a;
  assign alu_operand_b_o    = op_q.operand_b;
  assign alu_operand_c_o    = op_q.operand_c;
  assign alu_short_signed_o = op_q.short_signed;
  assign alu_imm_o          = op_q.imm;
  assign alu_dot_signed_o   = op_q.dot_signed;

endmodule

`default_nettype wire

// File: tb/tb_riscv_approx_issue.sv
// ============================================================================
//  Module  : tb_riscv_approx_issue
//  Brief   : Self-checking bench for riscv_approx_issue: directed scenarios
//            plus randomized traffic against a transaction-level model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_approx_issue;
  import riscv_approx_issue_pkg::*;

  localparam int OPW = APP_OP_WIDTH + 96 + 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    csr_we;
  logic [11:0]             csr_addr;
  logic [31:0]             csr_wdata;
  logic [31:0]             csr_rdata;
  logic                    in_valid;
  logic                    in_ready;
  logic [APP_OP_WIDTH-1:0] operator_i;
  logic [31:0]             operand_a_i, operand_b_i, operand_c_i;
  logic [1:0]              short_signed_i;
  logic [4:0]              imm_i;
  logic [1:0]              dot_signed_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [APP_OP_WIDTH-1:0] alu_operator;
  logic [31:0]             alu_a, alu_b, alu_c;
  logic [1:0]              alu_ss;
  logic [4:0]              alu_imm;
  logic [1:0]              alu_ds;
  logic [N_BIT_APPR-1:0]   approx_mask;
  logic [N_BIT_PREC-1:0]   prec_mask;
  logic                    busy;

  logic [OPW-1:0] out_vec;
  logic [OPW-1:0] in_vec;
  assign out_vec = {alu_operator, alu_a, alu_b, alu_c, alu_ss, alu_imm, alu_ds};
  assign in_vec  = {operator_i, operand_a_i, operand_b_i, operand_c_i,
                    short_signed_i, imm_i, dot_signed_i};

  int total = 0;
  int bad   = 0;

  logic [N_BIT_PREC-1:0] prec_ones;
  logic [31:0]           prec_ones_word;
  initial begin
    prec_ones      = '1;
    prec_ones_word = '0;
    prec_ones_word[N_BIT_PREC-1:0] = prec_ones;
  end

  always #5 clk = ~clk;

  riscv_approx_issue dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .csr_we_i           (csr_we),
    .csr_addr_i         (csr_addr),
    .csr_wdata_i        (csr_wdata),
    .csr_rdata_o        (csr_rdata),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .operator_i         (operator_i),
    .operand_a_i        (operand_a_i),
    .operand_b_i        (operand_b_i),
    .operand_c_i        (operand_c_i),
    .short_signed_i     (short_signed_i),
    .imm_i              (imm_i),
    .dot_signed_i       (dot_signed_i),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .alu_operator_o     (alu_operator),
    .alu_operand_a_o    (alu_a),
    .alu_operand_b_o    (alu_b),
    .alu_operand_c_o    (alu_c),
    .alu_short_signed_o (alu_ss),
    .alu_imm_o          (alu_imm),
    .alu_dot_signed_o   (alu_ds),
    .approx_mask_o      (approx_mask),
    .precision_mask_o   (prec_mask),
    .busy_o             (busy)
  );

  task automatic drive_op(input logic [OPW-1:0] v);
    {operator_i, operand_a_i, operand_b_i, operand_c_i,
     short_signed_i, imm_i, dot_signed_i} = v;
  endtask

  function automatic logic [OPW-1:0] mk_op(input logic [APP_OP_WIDTH-1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    return {op, a, b, c, 2'b01, 5'd3, 2'b10};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_op('0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n    = 1'b0;
    csr_addr = APPX_CSR_STAT;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0h exp 0", out_valid); end
    total++; if (approx_mask !== '0) begin bad++; $display("FAIL reset_approx: got %0h exp 0", approx_mask); end
    total++; if (prec_mask !== prec_ones) begin bad++; $display("FAIL reset_prec: got %0h exp %0h", prec_mask, prec_ones); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0h exp 1", in_ready); end
    total++; if (out_vec !== '0) begin bad++; $display("FAIL reset_fields: got %0h exp 0", out_vec); end
    cyc();
    rst_n = 1'b1;
    cyc();
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL reset_stat: got %0h exp 0", csr_rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h exp 0", busy); end
    csr_addr = APPX_CSR_PREC;
    #1;
    total++; if (csr_rdata !== prec_ones_word) begin bad++; $display("FAIL reset_prec_read: got %0h exp %0h", csr_rdata, prec_ones_word); end
    csr_addr = APPX_CSR_APPR;
    #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL reset_appr_read: got %0h exp 0", csr_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] op1, op2;
    op1 = mk_op(APP_MULMAC, 32'd3, 32'd5, 32'd10);
    op2 = mk_op(APP_MULMAC, 32'd2, 32'd2, 32'd0);
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_op(op1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %0h exp 1", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1: got %0h exp 1", out_valid); end
    total++; if (out_vec !== op1) begin bad++; $display("FAIL b2b_fields1: got %0h exp %0h", out_vec, op1); end
    drive_op(op2);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1: got %0h exp 1", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2: got %0h exp 1", out_valid); end
    total++; if (out_vec !== op2) begin bad++; $display("FAIL b2b_fields2: got %0h exp %0h", out_vec, op2); end
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid3: got %0h exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [OPW-1:0] op1, op2;
    op1 = mk_op(APP_DOT8, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    op2 = mk_op(APP_SLL, 32'hDEAD_BEEF, 32'h0000_0004, 32'h0);
    do_reset();
    in_valid = 1'b1;
    drive_op(op1);
    cyc();
    drive_op(op2);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (out_vec !== op1) begin bad++; $display("FAIL bp_stable[%0d]: got %0h exp %0h", i, out_vec, op1); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0h exp 0", i, in_ready); end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_retire: got %0h exp 1", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1 || out_vec !== op2) begin bad++; $display("FAIL bp_second: got v=%0h %0h exp v=1 %0h", out_valid, out_vec, op2); end
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %0h exp 0", out_valid); end
  endtask

  task automatic test_csr_held();
    do_reset();
    in_valid = 1'b1;
    drive_op(mk_op(APP_ADD, 32'd7, 32'd8, 32'd9));
    cyc();
    in_valid  = 1'b0;
    csr_we    = 1'b1;
    csr_addr  = APPX_CSR_APPR;
    csr_wdata = 32'h0000_0005;
    cyc();
    csr_we   = 1'b0;
    csr_addr = APPX_CSR_STAT;
    #1;
    total++; if (csr_rdata !== 32'd7) begin bad++; $display("FAIL held_stat: got %0h exp 7", csr_rdata); end
    total++; if (approx_mask !== '0) begin bad++; $display("FAIL held_mask_early: got %0h exp 0", approx_mask); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL held_ready: got %0h exp 0", in_ready); end
    csr_addr = APPX_CSR_APPR;
    #1;
    total++; if (csr_rdata !== 32'd5) begin bad++; $display("FAIL held_shadow: got %0h exp 5", csr_rdata); end
    cyc();
    out_ready = 1'b1;
    #1;
    total++; if (approx_mask !== '0) begin bad++; $display("FAIL held_mask_retire: got %0h exp 0", approx_mask); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL held_ready_retire: got %0h exp 0", in_ready); end
    cyc();
    total++; if (approx_mask !== 8'h05) begin bad++; $display("FAIL held_mask_applied: got %0h exp 5", approx_mask); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL held_ready_after: got %0h exp 1", in_ready); end
    csr_addr = APPX_CSR_STAT;
    #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL held_stat_after: got %0h exp 0", csr_rdata); end
  endtask

  task automatic test_csr_collision();
    do_reset();
    csr_we    = 1'b1;
    csr_addr  = APPX_CSR_APPR;
    csr_wdata = 32'h3;
    cyc();
    total++; if (approx_mask !== '0 || busy !== 1'b1) begin bad++; $display("FAIL coll_first: got mask=%0h busy=%0h exp 0 1", approx_mask, busy); end
    csr_wdata = 32'h7;
    cyc();
    csr_we   = 1'b0;
    csr_addr = APPX_CSR_STAT;
    #1;
    total++; if (approx_mask !== 8'h03) begin bad++; $display("FAIL coll_apply1: got %0h exp 3", approx_mask); end
    total++; if (csr_rdata !== 32'd2) begin bad++; $display("FAIL coll_pending: got %0h exp 2", csr_rdata); end
    cyc();
    total++; if (approx_mask !== 8'h07) begin bad++; $display("FAIL coll_apply2: got %0h exp 7", approx_mask); end
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL coll_stat_end: got %0h exp 0", csr_rdata); end
  endtask

  task automatic test_reset_drain();
    do_reset();
    in_valid = 1'b1;
    drive_op(mk_op(APP_MULMAC, 32'hA, 32'hB, 32'hC));
    cyc();
    in_valid  = 1'b0;
    csr_we    = 1'b1;
    csr_addr  = APPX_CSR_APPR;
    csr_wdata = 32'h9;
    cyc();
    csr_we   = 1'b0;
    csr_addr = APPX_CSR_STAT;
    #1;
    total++; if (csr_rdata !== 32'd7) begin bad++; $display("FAIL rd_stat_drain: got %0h exp 7", csr_rdata); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_vec !== '0) begin bad++; $display("FAIL rd_outputs: got v=%0h f=%0h exp 0 0", out_valid, out_vec); end
    total++; if (approx_mask !== '0 || prec_mask !== prec_ones) begin bad++; $display("FAIL rd_masks: got %0h %0h exp 0 %0h", approx_mask, prec_mask, prec_ones); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rd_ready_busy: got %0h %0h exp 1 0", in_ready, busy); end
    csr_addr = APPX_CSR_APPR;
    #1;
    total++; if (csr_rdata !== 32'd0) begin bad++; $display("FAIL rd_lost_write: got %0h exp 0", csr_rdata); end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [11:0] addrs [6];
    logic [127:0] rnd;
    // transaction-level model
    logic                  m_held, m_pend;
    logic [OPW-1:0]        m_op;
    logic [N_BIT_APPR-1:0] m_sh_appr, m_act_appr;
    logic [N_BIT_PREC-1:0] m_sh_prec, m_act_prec;
    logic [31:0]           m_cnt_ops, m_cnt_appr;
    logic                  exp_ready, acc, ret, apl, wa, wp, wc;
    logic [31:0]           exp_rdata;
    logic                  n_held, n_pend;
    logic [OPW-1:0]        n_op;
    logic [N_BIT_APPR-1:0] n_sh_appr, n_act_appr;
    logic [N_BIT_PREC-1:0] n_sh_prec, n_act_prec;
    logic [31:0]           n_cnt_ops, n_cnt_appr;

    addrs[0] = APPX_CSR_APPR;
    addrs[1] = APPX_CSR_PREC;
    addrs[2] = APPX_CSR_STAT;
    addrs[3] = APPX_CSR_STAT + 12'd1;
    addrs[4] = APPX_CSR_STAT + 12'd2;
    addrs[5] = 12'h123;

    do_reset();
    m_held = 1'b0; m_pend = 1'b0; m_op = '0;
    m_sh_appr = '0; m_act_appr = '0; m_sh_prec = '1; m_act_prec = '1;
    m_cnt_ops = '0; m_cnt_appr = '0;

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive_op(rnd[OPW-1:0]);
      csr_we    = ($urandom_range(0, 9) == 0);
      csr_addr  = addrs[$urandom_range(0, 5)];
      csr_wdata = $urandom();
      #1;

      exp_ready = !m_pend && (!m_held || out_ready);
      exp_rdata = '0;
      if (csr_addr == APPX_CSR_APPR) exp_rdata[N_BIT_APPR-1:0] = m_sh_appr;
      else if (csr_addr == APPX_CSR_PREC) exp_rdata[N_BIT_PREC-1:0] = m_sh_prec;
      else if (csr_addr == APPX_CSR_STAT) exp_rdata = {29'b0, m_held && m_pend, m_pend, m_held};
`ifdef RISCV_APPROX_PERF_CNT_EN
      else if (csr_addr == APPX_CSR_STAT + 12'd1) exp_rdata = m_cnt_ops;
      else if (csr_addr == APPX_CSR_STAT + 12'd2) exp_rdata = m_cnt_appr;
`endif

      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %0h exp %0h", n, in_ready, exp_ready); end
      total++; if (out_valid !== m_held) begin bad++; $display("FAIL rnd_valid@%0d: got %0h exp %0h", n, out_valid, m_held); end
      if (m_held) begin
        total++; if (out_vec !== m_op) begin bad++; $display("FAIL rnd_fields@%0d: got %0h exp %0h", n, out_vec, m_op); end
      end
      total++; if (approx_mask !== m_act_appr || prec_mask !== m_act_prec) begin bad++; $display("FAIL rnd_masks@%0d: got %0h %0h exp %0h %0h", n, approx_mask, prec_mask, m_act_appr, m_act_prec); end
      total++; if (busy !== (m_held || m_pend)) begin bad++; $display("FAIL rnd_busy@%0d: got %0h exp %0h", n, busy, m_held || m_pend); end
      total++; if (csr_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata@%0d addr=%0h: got %0h exp %0h", n, csr_addr, csr_rdata, exp_rdata); end

      // Masks move only at an operation boundary: idle, or the held op retiring
      acc = in_valid && exp_ready;
      ret = m_held && out_ready;
      apl = m_pend && (!m_held || ret);
      wa  = csr_we && (csr_addr == APPX_CSR_APPR);
      wp  = csr_we && (csr_addr == APPX_CSR_PREC);
      wc  = csr_we && ((csr_addr == APPX_CSR_STAT + 12'd1) || (csr_addr == APPX_CSR_STAT + 12'd2));
      n_act_appr = apl ? m_sh_appr : m_act_appr;
      n_act_prec = apl ? m_sh_prec : m_act_prec;
      n_sh_appr  = wa ? csr_wdata[N_BIT_APPR-1:0] : m_sh_appr;
      n_sh_prec  = wp ? csr_wdata[N_BIT_PREC-1:0] : m_sh_prec;
      n_pend     = (wa || wp) ? 1'b1 : (apl ? 1'b0 : m_pend);
      n_held     = acc ? 1'b1 : (ret ? 1'b0 : m_held);
      n_op       = acc ? in_vec : m_op;
      n_cnt_ops  = wc ? 32'd0 : (ret ? m_cnt_ops + 32'd1 : m_cnt_ops);
      n_cnt_appr = wc ? 32'd0 : ((ret && m_act_appr != '0) ? m_cnt_appr + 32'd1 : m_cnt_appr);

      cyc();
      m_held = n_held; m_pend = n_pend; m_op = n_op;
      m_sh_appr = n_sh_appr; m_sh_prec = n_sh_prec;
      m_act_appr = n_act_appr; m_act_prec = n_act_prec;
      m_cnt_ops = n_cnt_ops; m_cnt_appr = n_cnt_appr;
    end
    in_valid = 1'b0;
    csr_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_csr_held();
    test_csr_collision();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
